// File: rtl/axi_mem_pkg.sv
// Shared constants for the line-memory AXI slave: FSM encoding, response codes
// and line geometry.
package axi_mem_pkg;

    localparam int LINE_BYTES = 16;

    localparam logic [31:0] RESP_OKAY   = 32'd0;
    localparam logic [31:0] RESP_SLVERR = 32'd2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_RD_RESP = 3'd2;
    localparam logic [2:0] ST_WR_WAIT = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

endpackage

// File: rtl/line_mem_array.sv
// Single-port synchronous line RAM, 128-bit words with a per-byte write mask.
// Read data is registered and reflects the address presented on the previous edge.
module line_mem_array
    import axi_mem_pkg::*;
#(
    parameter int    IDX_W     = 12,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   addr_i,
    input  logic [127:0]       wdata_i,
    input  logic [15:0]        wmask_i,
    output logic [127:0]       rdata_o
);

    logic [127:0] mem_q [2**IDX_W];

    // NOTE: the storage array has no reset; clearing thousands of lines is not
    // implementable in a RAM macro, and contents must survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (wmask_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/axi_line_mem_slave.sv
// AXI-Lite line memory slave: one read or write in flight, fixed programmable
// latency, responses held until the master accepts them.
module axi_line_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int addrWidth = 16,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  readAddr_addr,
    input  logic         readAddr_valid,
    output logic         readAddr_ready,
    output logic [127:0] readData_data,
    output logic         readData_valid,
    input  logic         readData_ready,
    input  logic [31:0]  writeAddr_addr,
    input  logic         writeAddr_valid,
    output logic         writeAddr_ready,
    input  logic [127:0] writeData_data,
    input  logic [15:0]  writeData_strb,
    input  logic         writeData_valid,
    output logic         writeData_ready,
    output logic [31:0]  writeResp_msg,
    output logic         writeResp_valid,
    input  logic         writeResp_ready
);

    localparam int IDX_W = addrWidth - 4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             oor_q, oor_d;
    logic [127:0]     wdata_q, wdata_d;
    logic [15:0]      strb_q, strb_d;
    logic [127:0]     rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      bmsg_q, bmsg_d;
    logic             bvalid_q, bvalid_d;

    logic             in_idle;
    logic             wr_pair;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [127:0]     ram_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};

    // Readys are combinational but must stay low while reset is asserted.
    assign in_idle = (state_q == ST_IDLE) && rst;
    assign wr_pair = writeAddr_valid && writeData_valid;

    // Idle presents the incoming read line so the RAM output is already valid
    // when RD_LAT is 1.
    assign ram_addr = (state_q == ST_IDLE) ? readAddr_addr[addrWidth-1:4] : idx_q;

    line_mem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .wmask_i (strb_q),
        .rdata_o (ram_rdata)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        oor_d           = oor_q;
        wdata_d         = wdata_q;
        strb_d          = strb_q;
        rdata_d         = rdata_q;
        rvalid_d        = rvalid_q;
        bmsg_d          = bmsg_q;
        bvalid_d        = bvalid_q;
        readAddr_ready  = 1'b0;
        writeAddr_ready = 1'b0;
        writeData_ready = 1'b0;
        ram_we          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_idle && wr_pair) begin
                    writeAddr_ready = 1'b1;
                    writeData_ready = 1'b1;
                    idx_d           = writeAddr_addr[addrWidth-1:4];
                    oor_d           = (writeAddr_addr[31:addrWidth] != '0);
                    wdata_d         = writeData_data;
                    strb_d          = writeData_strb;
                    cnt_d           = 4'(WR_LAT - 1);
                    state_d         = ST_WR_WAIT;
                end else if (in_idle && readAddr_valid) begin
                    readAddr_ready = 1'b1;
                    idx_d          = readAddr_addr[addrWidth-1:4];
                    oor_d          = (readAddr_addr[31:addrWidth] != '0);
                    cnt_d          = 4'(RD_LAT - 1);
                    state_d        = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = oor_q ? '0 : ram_rdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RD_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RD_RESP: begin
                if (readData_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ram_we   = !oor_q;
                    bmsg_d   = oor_q ? RESP_SLVERR : RESP_OKAY;
                    bvalid_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR_RESP: begin
                if (writeResp_ready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bmsg_q   <= RESP_OKAY;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            bmsg_q   <= bmsg_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign readData_data   = rdata_q;
    assign readData_valid  = rvalid_q;
    assign writeResp_msg   = bmsg_q;
    assign writeResp_valid = bvalid_q;

endmodule

// File: tb/tb_axi_line_mem_slave.sv
// Directed bench for axi_line_mem_slave: a transaction-level model predicts
// readys, valids and payloads every cycle; literal checks pin key results.
module tb_axi_line_mem_slave;
    import axi_mem_pkg::*;

    localparam int AW = 16;
    localparam int RL = 4;
    localparam int WL = 2;

    localparam logic [127:0] D1       = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] D3       = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D4       = {16{8'hEE}};
    localparam logic [127:0] D5       = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] LINE11   = {16{8'h11}};
    localparam logic [127:0] LINEAA   = {16{8'hAA}};
    localparam logic [127:0] EXP_PART = 128'h11111111_11111111_11111111_AAAAAAAA;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  readAddr_addr = '0;
    logic         readAddr_valid = 1'b0;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready = 1'b1;
    logic [31:0]  writeAddr_addr = '0;
    logic         writeAddr_valid = 1'b0;
    logic         writeAddr_ready;
    logic [127:0] writeData_data = '0;
    logic [15:0]  writeData_strb = '0;
    logic         writeData_valid = 1'b0;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    axi_line_mem_slave #(
        .addrWidth (AW),
        .RD_LAT    (RL),
        .WR_LAT    (WL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .readAddr_addr   (readAddr_addr),
        .readAddr_valid  (readAddr_valid),
        .readAddr_ready  (readAddr_ready),
        .readData_data   (readData_data),
        .readData_valid  (readData_valid),
        .readData_ready  (readData_ready),
        .writeAddr_addr  (writeAddr_addr),
        .writeAddr_valid (writeAddr_valid),
        .writeAddr_ready (writeAddr_ready),
        .writeData_data  (writeData_data),
        .writeData_strb  (writeData_strb),
        .writeData_valid (writeData_valid),
        .writeData_ready (writeData_ready),
        .writeResp_msg   (writeResp_msg),
        .writeResp_valid (writeResp_valid),
        .writeResp_ready (writeResp_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within cycle budget", name);
    endtask

    // Transaction model: memory as an associative array of lines, response
    // time = handshake cycle + latency.
    logic [127:0] mmem [int];
    bit           m_busy = 0, m_wr = 0, m_up = 0, m_oor = 0;
    int           m_due = 0, m_idx = 0;
    logic [127:0] m_wdata = '0, m_line = '0;
    logic [15:0]  m_strb = '0;
    logic         e_rvalid = 1'b0, e_bvalid = 1'b0;
    logic [127:0] e_rdata = '0;
    logic [31:0]  e_msg = '0;
    bit           e_rknown = 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_up = 0;
            e_rvalid = 1'b0; e_bvalid = 1'b0; e_rdata = '0; e_msg = '0; e_rknown = 1;
        end else begin
            cyc++;
            if (m_busy && m_up) begin
                if (!m_wr && readData_ready) begin
                    m_busy = 0; m_up = 0; e_rvalid = 1'b0;
                end else if (m_wr && writeResp_ready) begin
                    m_busy = 0; m_up = 0; e_bvalid = 1'b0;
                end
            end else if (!m_busy) begin
                if (writeAddr_valid && writeData_valid) begin
                    m_busy = 1; m_wr = 1; m_due = cyc + WL;
                    m_idx = int'(writeAddr_addr[AW-1:4]);
                    m_oor = (writeAddr_addr[31:AW] != '0);
                    m_wdata = writeData_data; m_strb = writeData_strb;
                end else if (readAddr_valid) begin
                    m_busy = 1; m_wr = 0; m_due = cyc + RL;
                    m_idx = int'(readAddr_addr[AW-1:4]);
                    m_oor = (readAddr_addr[31:AW] != '0);
                end
            end
            if (m_busy && !m_up && cyc == m_due) begin
                m_up = 1;
                if (m_wr) begin
                    if (!m_oor) begin
                        m_line = mmem.exists(m_idx) ? mmem[m_idx] : 'x;
                        for (int b = 0; b < 16; b++)
                            if (m_strb[b]) m_line[8*b +: 8] = m_wdata[8*b +: 8];
                        mmem[m_idx] = m_line;
                        e_msg = RESP_OKAY;
                    end else begin
                        e_msg = RESP_SLVERR;
                    end
                    e_bvalid = 1'b1;
                end else begin
                    e_rdata = m_oor ? '0 : (mmem.exists(m_idx) ? mmem[m_idx] : 'x);
                    e_rknown = !$isunknown(e_rdata);
                    e_rvalid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_idle, e_wr, e_rd;
        e_idle = rst && !m_busy;
        e_wr   = e_idle && writeAddr_valid && writeData_valid;
        e_rd   = e_idle && readAddr_valid && !(writeAddr_valid && writeData_valid);
        check_bit("cyc_readAddr_ready", readAddr_ready, e_rd);
        check_bit("cyc_writeAddr_ready", writeAddr_ready, e_wr);
        check_bit("cyc_writeData_ready", writeData_ready, e_wr);
        check_bit("cyc_readData_valid", readData_valid, e_rvalid);
        check_bit("cyc_writeResp_valid", writeResp_valid, e_bvalid);
        if (e_rvalid && e_rknown) check_val("cyc_readData_data", readData_data, e_rdata);
        if (e_bvalid) check_val("cyc_writeResp_msg", {96'd0, writeResp_msg}, {96'd0, e_msg});
    end

    task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                            output logic [31:0] msg);
        bit ok;
        @(posedge clk); #1;
        writeAddr_addr = a; writeData_data = d; writeData_strb = s;
        writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = writeAddr_ready; end
        if (!ok) timed_out("write_accept");
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = writeResp_valid && writeResp_ready;
        end
        if (!ok) timed_out("write_resp");
        msg = writeResp_msg;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d, output int lat);
        bit ok;
        int hs;
        @(posedge clk); #1;
        readAddr_addr = a; readAddr_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = readAddr_ready; end
        if (!ok) timed_out("read_accept");
        @(posedge clk); #1;
        hs = cyc;
        readAddr_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = readData_valid; end
        if (!ok) timed_out("read_data");
        lat = cyc - hs;
        d = readData_data;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (readData_valid && readData_ready) ok = 1; else @(negedge clk);
        end
        if (!ok) timed_out("read_handshake");
        @(posedge clk); #1;
    endtask

    task automatic wait_neg(input string name, input int which);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            case (which)
                0: ok = writeAddr_ready;
                1: ok = readAddr_ready;
                default: ok = readData_valid;
            endcase
        end
        if (!ok) timed_out(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  msg;
        logic [127:0] d;
        int           lat;

        // Reset with every valid asserted: readys must stay low.
        readAddr_valid = 1'b1; writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_readData_data", readData_data, 128'd0);
        check_val("rst_writeResp_msg", {96'd0, writeResp_msg}, 128'd0);
        @(posedge clk); #1;
        readAddr_valid = 1'b0; writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Full write, then read of the same line at a different byte offset.
        do_write(32'h0040, D1, 16'hFFFF, msg);
        check_val("wr_okay", {96'd0, msg}, {96'd0, RESP_OKAY});
        do_read(32'h004C, d, lat);
        check_val("rd_line", d, D1);
        check_val("rd_latency", 128'(lat), 128'(RL));

        // Partial write over a line of 0x11 bytes.
        do_write(32'h0080, LINE11, 16'hFFFF, msg);
        do_write(32'h0080, LINEAA, 16'h000F, msg);
        do_read(32'h0080, d, lat);
        check_val("partial_write", d, EXP_PART);

        // Simultaneous write pair and read on the same line: write first.
        @(posedge clk); #1;
        writeAddr_addr = 32'h00C0; writeData_data = D3; writeData_strb = 16'hFFFF;
        writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        readAddr_addr = 32'h00C0; readAddr_valid = 1'b1;
        wait_neg("rw_write_accept", 0);
        check_bit("rw_read_held", readAddr_ready, 1'b0);
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        wait_neg("rw_read_accept", 1);
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        wait_neg("rw_read_data", 2);
        check_val("rw_new_data", readData_data, D3);
        @(posedge clk); #1;

        // Read backpressure for 7 cycles with another read pending.
        readData_ready = 1'b0;
        readAddr_addr = 32'h0040; readAddr_valid = 1'b1;
        wait_neg("bp_accept", 1);
        @(posedge clk); #1;
        readAddr_addr = 32'h0080;
        wait_neg("bp_data", 2);
        for (int i = 1; i <= 7; i++) begin
            check_val("bp_data_stable", readData_data, D1);
            check_bit("bp_valid_stable", readData_valid, 1'b1);
            check_bit("bp_no_accept", readAddr_ready, 1'b0);
            if (i < 7) @(negedge clk);
        end
        @(posedge clk); #1;
        readData_ready = 1'b1;
        @(posedge clk); #1;
        check_bit("bp_valid_dropped", readData_valid, 1'b0);
        @(negedge clk);
        check_bit("bp_next_accept", readAddr_ready, 1'b1);
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        wait_neg("bp_next_data", 2);
        check_val("bp_next_line", readData_data, EXP_PART);
        @(posedge clk); #1;

        // Out-of-range write leaves line 0 untouched and reports SLVERR.
        do_write(32'h0000, D5, 16'hFFFF, msg);
        do_write(32'h0001_0000, D4, 16'hFFFF, msg);
        check_val("oor_slverr", {96'd0, msg}, {96'd0, RESP_SLVERR});
        do_read(32'h0001_0000, d, lat);
        check_val("oor_read_zero", d, 128'd0);
        do_read(32'h0000, d, lat);
        check_val("oor_line0_intact", d, D5);

        // Reset during RD_WAIT: everything drops, array contents survive.
        @(posedge clk); #1;
        readAddr_addr = 32'h0040; readAddr_valid = 1'b1;
        wait_neg("mid_rst_accept", 1);
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        @(posedge clk); #3;
        readAddr_valid = 1'b1; writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        rst = 1'b0;
        #1;
        check_bit("mid_rst_readAddr_ready", readAddr_ready, 1'b0);
        check_bit("mid_rst_writeAddr_ready", writeAddr_ready, 1'b0);
        check_bit("mid_rst_readData_valid", readData_valid, 1'b0);
        check_bit("mid_rst_writeResp_valid", writeResp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        readAddr_valid = 1'b0; writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        do_read(32'h0040, d, lat);
        check_val("post_rst_line", d, D1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
